stage_fetch: RTL and testbench
==============================

Name: stage_fetch

Overview:
Instruction fetch stage and producer side of the instruction word consumed by stage_decode. It holds the program counter and issues one request at a time to instruction memory over a request/grant/response interface. It presents each fetched word with its PC to decode through a valid/ready handshake, and redirects the PC on taken jumps and branches, discarding any stale in-flight fetch.

Parameters:
INSTR_SIZE, 32, instruction word width (matches PARAMS_pkg)
ADDR_SIZE, 32, PC / fetch address width
RESET_PC, 32'h0000_1000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, value driven on instr_o when no valid instruction is held

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  ADDR_SIZE  fetch address, word aligned
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  INSTR_SIZE  response instruction word
instr_o  out  INSTR_SIZE  instruction to decode
pc_o  out  ADDR_SIZE  address of instr_o
instr_valid_o  out  1  instr_o/pc_o valid
instr_ready_i  in  1  decode accepts instruction
redirect_i  in  1  taken jump/branch, one-cycle pulse
redirect_pc_i  in  ADDR_SIZE  redirect target

Behaviour:
- Reset, asynchronous and active-low, may occur at any cycle:
  - state=REQ, pc_q=RESET_PC, req_pc_q=RESET_PC.
  - Held buffer cleared: instr_o=NOP_INSTR, pc_o=RESET_PC, instr_valid_o=0.
  - imem_req_o=0 while reset_n=0.
- A response outstanding at reset is forgotten. The memory side is reset together with this block.
- At most one outstanding memory request at any time.
- The memory never returns rvalid in the same cycle as gnt.
- States:
  - REQ: imem_req_o=1, imem_addr_o=pc_q. On gnt: req_pc_q<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^ADDR_SIZE), go to WAIT.
  - WAIT: imem_req_o=0. On rvalid: instr_q<=imem_rdata_i, pc_o<=req_pc_q, instr_valid_o<=1, go to HOLD.
  - HOLD: instr_valid_o=1; instr_o and pc_o held stable. On instr_ready_i: instr_valid_o<=0, instr_o<=NOP_INSTR, go to REQ.
  - DROP: imem_req_o=0. On rvalid: discard data, go to REQ.
- imem_addr_o = pc_q in every state; it is only meaningful when imem_req_o=1.
- Latency: gnt in cycle N, rvalid in N+k (k>=1), instr_valid_o high from N+k+1. Minimum 3 cycles per instruction.
- Redirect (redirect_i=1) has priority over every other event in the same cycle. In all cases pc_q<=redirect_pc_i with bits[1:0] forced to 0.
  - REQ without gnt: stay REQ; the next request uses the new PC.
  - REQ with gnt the same cycle: the granted fetch is stale, go to DROP; req_pc_q is not updated.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid the same cycle: discard data, go to REQ.
  - HOLD: instr_valid_o<=0, go to REQ. If instr_ready_i is also high, the handshake counts as completed and the instruction is not re-presented.
  - DROP: stay DROP; if rvalid arrives the same cycle, go to REQ.
- Back-to-back redirects: the last one wins.
- instr_valid_o never rises in the cycle a redirect is seen.

Test Plan:
- Reset release, memory grants immediately, rvalid 1 cycle later with rdata 0x00500093 -> addr 0x1000 in cycle 1, instr_valid_o in cycle 3 with instr_o=0x00500093, pc_o=0x1000; next request addr 0x1004.
- Decode holds instr_ready_i=0 for 5 cycles -> instr_o/pc_o stable, no new imem_req_o; ready=1 -> next request to 0x1004 the following cycle.
- Redirect to 0x2002 while in WAIT for 0x1004, then rvalid with 0xDEADBEEF -> data dropped, no instr_valid_o, next request addr 0x2000.
- Redirect to 0x3000 in HOLD with instr_ready_i=1 the same cycle -> valid drops, next request 0x3000, old instruction not repeated.
- Redirect to 0x4000 in the same cycle as gnt for 0x1008 -> DROP entered; response discarded; next request 0x4000.
- reset_n asserted mid-WAIT -> outputs return to reset values immediately (asynchronously), first request after release is 0x1000; pc_q=0xFFFFFFFC fetch -> next pc_q=0x00000000.

Source files
------------

// File: rtl/stage_fetch_if.sv
// Bundle between the fetch stage, instruction memory and the decode stage.
// The master side is the fetch stage; the slave side is its environment
// (instruction memory, decode and the branch/jump redirect source).
interface stage_fetch_if #(
  parameter int INSTR_SIZE = 32,
  parameter int ADDR_SIZE  = 32
);

  // Instruction memory request/grant/response
  logic                  imem_req_o;
  logic [ADDR_SIZE-1:0]  imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [INSTR_SIZE-1:0] imem_rdata_i;

  // Decode valid/ready handshake
  logic [INSTR_SIZE-1:0] instr_o;
  logic [ADDR_SIZE-1:0]  pc_o;
  logic                  instr_valid_o;
  logic                  instr_ready_i;

  // Taken jump/branch redirect
  logic                  redirect_i;
  logic [ADDR_SIZE-1:0]  redirect_pc_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output instr_o,
    output pc_o,
    output instr_valid_o,
    input  instr_ready_i,
    input  redirect_i,
    input  redirect_pc_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  instr_o,
    input  pc_o,
    input  instr_valid_o,
    output instr_ready_i,
    output redirect_i,
    output redirect_pc_i
  );

endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction memory
// request in flight, hands each fetched word to decode over valid/ready and
// follows taken jumps/branches, throwing away any fetch that became stale.
module stage_fetch #(
  parameter int                    INSTR_SIZE = 32,
  parameter int                    ADDR_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = 32'h0000_1000,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset_n,
  stage_fetch_if.master bus
);

  // REQ: asking memory; WAIT: granted, awaiting data; HOLD: word offered to
  // decode; DROP: awaiting the response of a fetch made stale by a redirect.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_SIZE-1:0]  pc_q;
  logic [ADDR_SIZE-1:0]  req_pc_q;
  logic [INSTR_SIZE-1:0] instr_q;
  logic [ADDR_SIZE-1:0]  pc_out_q;
  logic                  valid_q;
  logic [ADDR_SIZE-1:0]  redirect_target;

  // Redirect targets are always word aligned, whatever the low bits say.
  assign redirect_target = {bus.redirect_pc_i[ADDR_SIZE-1:2], 2'b00};

  // The request is a decode of the state, held low while reset is asserted
  // so memory sees nothing during reset even though the state already reads REQ.
  assign bus.imem_req_o    = reset_n && (state == REQ);
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_out_q;
  assign bus.instr_valid_o = valid_q;

  // Fetch FSM with the PC and the decode-side buffer; a redirect beats
  // every other event seen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (bus.redirect_i) begin
            pc_q <= redirect_target;
            if (bus.imem_gnt_i) begin
              state <= DROP;
            end
          end else if (bus.imem_gnt_i) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + ADDR_SIZE'(4);
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (bus.redirect_i) begin
            pc_q  <= redirect_target;
            state <= bus.imem_rvalid_i ? REQ : DROP;
          end else if (bus.imem_rvalid_i) begin
            instr_q  <= bus.imem_rdata_i;
            pc_out_q <= req_pc_q;
            valid_q  <= 1'b1;
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (bus.redirect_i) begin
            pc_q    <= redirect_target;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            state   <= REQ;
          end else if (bus.instr_ready_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            state   <= REQ;
          end
        end

        DROP: begin
          if (bus.redirect_i) begin
            pc_q <= redirect_target;
          end
          if (bus.imem_rvalid_i) begin
            state <= REQ;
          end
        end

        default: begin
          state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: a table of fetch transactions plus hand-written
// redirect, reset and PC-wrap sequences, with a scoreboard of expected words.
module tb_stage_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct {
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    int          rdy_dly;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t last_exp;
  vec_t vecs[4];

  stage_fetch_if #(.INSTR_SIZE(32), .ADDR_SIZE(32)) bus ();

  stage_fetch dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Last-resort guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitReq();
    int n = 0;
    while (bus.imem_req_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_wait", 32'(bus.imem_req_o), 32'd1);
  endtask

  // Request, grant and answer one fetch, recording what decode must see
  task automatic applyStimulus(input int gnt_dly, input int rv_dly,
                               input logic [31:0] rdata, input logic [31:0] exp_addr);
    exp_t e;
    waitReq();
    chk("req_addr", bus.imem_addr_o, exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      chk("req_held", 32'(bus.imem_req_o), 32'd1);
      chk("req_addr_held", bus.imem_addr_o, exp_addr);
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    chk("req_after_gnt", 32'(bus.imem_req_o), 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      tick();
      chk("valid_in_wait", 32'(bus.instr_valid_o), 32'd0);
      chk("req_in_wait", 32'(bus.imem_req_o), 32'd0);
    end
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = rdata;
    e.pc    = exp_addr;
    e.instr = rdata;
    sb.push_back(e);
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
  endtask

  // Compare the word offered to decode with the oldest scoreboard entry
  task automatic checkOutput();
    chk("instr_valid", 32'(bus.instr_valid_o), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      last_exp = sb.pop_front();
      chk("instr_o", bus.instr_o, last_exp.instr);
      chk("pc_o", bus.pc_o, last_exp.pc);
    end
  endtask

  // Decode stalls for a while, then takes the word
  task automatic acceptInstr(input int rdy_dly);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("hold_valid", 32'(bus.instr_valid_o), 32'd1);
      chk("hold_instr", bus.instr_o, last_exp.instr);
      chk("hold_pc", bus.pc_o, last_exp.pc);
      chk("hold_no_req", 32'(bus.imem_req_o), 32'd0);
    end
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    chk("accept_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("accept_nop", bus.instr_o, NOP_INSTR);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{gnt_dly: 0, rv_dly: 0, rdata: 32'h0050_0093, rdy_dly: 5, exp_addr: 32'h0000_1000};
    vecs[1] = '{gnt_dly: 2, rv_dly: 3, rdata: 32'h00A0_0113, rdy_dly: 0, exp_addr: 32'h0000_1004};
    vecs[2] = '{gnt_dly: 1, rv_dly: 1, rdata: 32'h0020_81B3, rdy_dly: 2, exp_addr: 32'h0000_1008};
    vecs[3] = '{gnt_dly: 0, rv_dly: 4, rdata: 32'hFFF0_0213, rdy_dly: 1, exp_addr: 32'h0000_100C};

    reset_n           = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;

    tick();
    tick();
    chk("rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_instr", bus.instr_o, NOP_INSTR);
    chk("rst_pc", bus.pc_o, RESET_PC);
    reset_n = 1'b1;
    #1;
    chk("first_req", 32'(bus.imem_req_o), 32'd1);
    chk("first_addr", bus.imem_addr_o, RESET_PC);
    tick();

    // Table-driven sequential fetches
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].gnt_dly, vecs[v].rv_dly, vecs[v].rdata, vecs[v].exp_addr);
      checkOutput();
      acceptInstr(vecs[v].rdy_dly);
    end

    // Redirect while waiting for data: the late response is dropped
    waitReq();
    chk("seqA_addr", bus.imem_addr_o, 32'h0000_1010);
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_2002;
    tick();
    bus.redirect_i = 1'b0;
    chk("seqA_drop_req", 32'(bus.imem_req_o), 32'd0);
    chk("seqA_drop_valid", 32'(bus.instr_valid_o), 32'd0);
    tick();
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("seqA_no_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("seqA_req", 32'(bus.imem_req_o), 32'd1);
    chk("seqA_addr_new", bus.imem_addr_o, 32'h0000_2000);
    applyStimulus(0, 0, 32'h0010_0513, 32'h0000_2000);
    checkOutput();
    acceptInstr(0);

    // Redirect in HOLD together with ready: no re-presentation
    applyStimulus(0, 1, 32'h0020_0593, 32'h0000_2004);
    checkOutput();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_3000;
    bus.instr_ready_i = 1'b1;
    tick();
    bus.redirect_i    = 1'b0;
    bus.instr_ready_i = 1'b0;
    chk("seqB_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("seqB_nop", bus.instr_o, NOP_INSTR);
    chk("seqB_req", 32'(bus.imem_req_o), 32'd1);
    chk("seqB_addr", bus.imem_addr_o, 32'h0000_3000);
    tick();
    tick();
    chk("seqB_not_repeated", 32'(bus.instr_valid_o), 32'd0);

    // Redirect in the same cycle as grant: granted fetch is stale
    bus.imem_gnt_i    = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_4000;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.redirect_i = 1'b0;
    chk("seqC_drop_req", 32'(bus.imem_req_o), 32'd0);
    tick();
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hBAD0_BAD0;
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("seqC_no_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("seqC_addr", bus.imem_addr_o, 32'h0000_4000);
    applyStimulus(1, 0, 32'h0030_0613, 32'h0000_4000);
    checkOutput();
    acceptInstr(0);

    // Asynchronous reset in the middle of a WAIT
    waitReq();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("seqD_req", 32'(bus.imem_req_o), 32'd0);
    chk("seqD_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("seqD_instr", bus.instr_o, NOP_INSTR);
    chk("seqD_pc", bus.pc_o, RESET_PC);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("seqD_restart_addr", bus.imem_addr_o, RESET_PC);
    applyStimulus(0, 0, 32'h0040_0693, RESET_PC);
    checkOutput();
    acceptInstr(0);

    // Redirect without grant, then fetch across the top of the address space
    waitReq();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    bus.redirect_i = 1'b0;
    chk("seqE_req", 32'(bus.imem_req_o), 32'd1);
    chk("seqE_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    applyStimulus(0, 2, 32'h1357_9BDF, 32'hFFFF_FFFC);
    checkOutput();
    acceptInstr(1);
    waitReq();
    chk("seqE_wrap", bus.imem_addr_o, 32'h0000_0000);

    // Back-to-back redirects: the last target wins
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_5000;
    tick();
    bus.redirect_pc_i = 32'h0000_6000;
    tick();
    bus.redirect_i = 1'b0;
    chk("seqF_addr", bus.imem_addr_o, 32'h0000_6000);
    applyStimulus(0, 0, 32'h0050_0713, 32'h0000_6000);
    checkOutput();
    acceptInstr(0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
